hdr_cmd_sequencer: RTL and testbench

//  Fetches a queue of HDR command descriptors from the register file and drives them into hdr_engine.

---
 rtl/hdr_pkg.sv | 37 +++
 rtl/hdr_cmd_sequencer_if.sv | 36 +++
 rtl/hdr_seq_watchdog.sv | 30 +++
 rtl/hdr_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_hdr_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR command sequencer: FSM states, the legal
// HDR-DDR mode code and the descriptor byte layout.
package hdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_WAIT_EXIT = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_t;

  localparam logic [2:0] MODE_HDR_DDR = 3'd6;

  localparam int DESC_CP_BIT   = 0;
  localparam int DESC_TOC_BIT  = 1;
  localparam int DESC_MODE_LSB = 2;
  localparam int DESC_MODE_MSB = 4;

  typedef struct packed {
    logic       cp;
    logic       toc;
    logic [2:0] mode;
  } desc_t;

  // Bits [7:5] of the descriptor byte are reserved and never looked at.
  function automatic desc_t decode_desc(input logic [DESC_MODE_MSB:0] raw);
    desc_t d;
    d.cp   = raw[DESC_CP_BIT];
    d.toc  = raw[DESC_TOC_BIT];
    d.mode = raw[DESC_MODE_MSB:DESC_MODE_LSB];
    return d;
  endfunction

endpackage

// File: rtl/hdr_cmd_sequencer_if.sv
// Handshake bundle between the sequencer, its register file, hdr_engine and
// the per-command completion sources.
interface hdr_cmd_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              i_start;
  logic              i_abort;
  logic [3:0]        i_cmd_count;
  logic [7:0]        i_regf_rd_data;
  logic              o_regf_rd_en;
  logic [ADDR_W-1:0] o_regf_addr;
  logic              o_hdrengine_en;
  logic              o_cp;
  logic              o_toc;
  logic [2:0]        o_mode;
  logic              i_ccc_done;
  logic              i_ddr_mode_done;
  logic              i_hdrengine_done;
  logic              o_done;
  logic              o_error;

  // master: the sequencer itself; slave: everything around it.
  modport master (
    input  i_start, i_abort, i_cmd_count, i_regf_rd_data,
    input  i_ccc_done, i_ddr_mode_done, i_hdrengine_done,
    output o_regf_rd_en, o_regf_addr, o_hdrengine_en,
    output o_cp, o_toc, o_mode, o_done, o_error
  );

  modport slave (
    output i_start, i_abort, i_cmd_count, i_regf_rd_data,
    output i_ccc_done, i_ddr_mode_done, i_hdrengine_done,
    input  o_regf_rd_en, o_regf_addr, o_hdrengine_en,
    input  o_cp, o_toc, o_mode, o_done, o_error
  );
endinterface

// File: rtl/hdr_seq_watchdog.sv
// Wait-for-done watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT_CYC-th one.
module hdr_seq_watchdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_reg;

  // Saturates at the expiry value so a stalled sequencer cannot wrap around.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST_CNT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST_CNT);

endmodule

// File: rtl/hdr_cmd_sequencer.sv
// Walks a ring of HDR descriptors in the register file and feeds them one at a
// time into hdr_engine, closing the burst on the engine's exit handshake.
module hdr_cmd_sequencer
  import hdr_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'd200,
  parameter int                QUEUE_DEPTH = 8,
  parameter int                TIMEOUT_CYC = 1023
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  hdr_cmd_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  seq_state_t        state_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [3:0]        remaining_reg;
  logic              rd_en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              en_reg;
  logic              cp_reg;
  logic              toc_reg;
  logic [2:0]        mode_reg;
  logic              done_reg;
  logic              error_reg;

  logic              any_done;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic [PTR_W-1:0]  ptr_next;
  desc_t             desc_in;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] p);
    return BASE_ADDR + ADDR_W'(p);
  endfunction

  // Both completion sources together are still a single completion.
  assign any_done  = bus.i_ccc_done | bus.i_ddr_mode_done;
  assign ptr_next  = ptr_reg + 1'b1;
  assign desc_in   = decode_desc(bus.i_regf_rd_data[DESC_MODE_MSB:0]);
  assign wd_enable = (state_reg == ST_RUN) || (state_reg == ST_WAIT_EXIT);
  assign wd_clear  = (state_reg == ST_LOAD) || ((state_reg == ST_RUN) && any_done);

  hdr_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .expired     (wd_expired)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      rd_en_reg     <= 1'b0;
      addr_reg      <= BASE_ADDR;
      en_reg        <= 1'b0;
      cp_reg        <= 1'b0;
      toc_reg       <= 1'b0;
      mode_reg      <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else if (bus.i_abort) begin
      state_reg <= ST_IDLE;
      rd_en_reg <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      rd_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_start) begin
            error_reg     <= 1'b0;
            remaining_reg <= bus.i_cmd_count;
            if (bus.i_cmd_count == 4'd0) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              rd_en_reg <= 1'b1;
              addr_reg  <= slot_addr(ptr_reg);
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          // The last descriptor of a burst always requests the exit.
          cp_reg   <= desc_in.cp;
          toc_reg  <= desc_in.toc | (remaining_reg == 4'd1);
          mode_reg <= desc_in.mode;
          if (desc_in.mode != MODE_HDR_DDR) begin
            en_reg    <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end else begin
            en_reg    <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (any_done) begin
            remaining_reg <= remaining_reg - 4'd1;
            ptr_reg       <= ptr_next;
            if (toc_reg) begin
              state_reg <= ST_WAIT_EXIT;
            end else begin
              rd_en_reg <= 1'b1;
              addr_reg  <= slot_addr(ptr_next);
              state_reg <= ST_FETCH;
            end
          end else if (wd_expired) begin
            en_reg    <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end
        ST_WAIT_EXIT: begin
          if (bus.i_hdrengine_done) begin
            en_reg    <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (wd_expired) begin
            en_reg    <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end
        ST_DONE: begin
          cp_reg    <= 1'b0;
          toc_reg   <= 1'b0;
          mode_reg  <= '0;
          state_reg <= ST_IDLE;
        end
        ST_ERROR: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_regf_rd_en   = rd_en_reg;
  assign bus.o_regf_addr    = addr_reg;
  assign bus.o_hdrengine_en = en_reg;
  assign bus.o_cp           = cp_reg;
  assign bus.o_toc          = toc_reg;
  assign bus.o_mode         = mode_reg;
  assign bus.o_done         = done_reg;
  assign bus.o_error        = error_reg;

endmodule

// File: tb/tb_hdr_cmd_sequencer.sv
// Directed plus randomized bursts for hdr_cmd_sequencer, checked cycle by cycle
// against a transaction-level expectation of the descriptor ring.
module tb_hdr_cmd_sequencer;

  localparam int          ADDR_W = 12;
  localparam logic [11:0] BASE   = 12'd200;
  localparam int          DEPTH  = 8;
  localparam int          TMO    = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdr_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  hdr_cmd_sequencer #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .QUEUE_DEPTH (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus.master)
  );

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          fail_cnt = 0;
  logic [7:0]  desc_mem [DEPTH];
  int          ptr_m = 0;
  logic        hold_cp = 1'b0, hold_toc = 1'b0, err_m = 1'b0;
  logic [2:0]  hold_mode = 3'd0;
  logic        prev_rd_en = 1'b0;
  logic [11:0] prev_addr = 12'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: release pulse inputs and answer last cycle's regfile read.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_start          = 1'b0;
    bus.i_abort          = 1'b0;
    bus.i_ccc_done       = 1'b0;
    bus.i_ddr_mode_done  = 1'b0;
    bus.i_hdrengine_done = 1'b0;
    if (prev_rd_en) bus.i_regf_rd_data = desc_mem[(int'(prev_addr) - int'(BASE)) & (DEPTH - 1)];
    else            bus.i_regf_rd_data = 8'($urandom);
    prev_rd_en = bus.o_regf_rd_en;
    prev_addr  = bus.o_regf_addr;
  endtask

  function automatic logic [7:0] mk(input logic cp, input logic toc, input logic [2:0] mode);
    return {3'b000, mode, toc, cp};
  endfunction

  task automatic fill_random();
    logic [2:0] m;
    for (int s = 0; s < DEPTH; s++) begin
      m = 3'd6;
      if ($urandom_range(0, 19) == 0) begin
        m = 3'($urandom_range(0, 6));
        if (m == 3'd6) m = 3'd7;
      end
      desc_mem[s] = {3'($urandom), m, ($urandom_range(0, 5) == 0), 1'($urandom)};
    end
  endtask

  task automatic drive_done();
    case ($urandom_range(1, 3))
      1:       bus.i_ccc_done = 1'b1;
      2:       bus.i_ddr_mode_done = 1'b1;
      default: begin bus.i_ccc_done = 1'b1; bus.i_ddr_mode_done = 1'b1; end
    endcase
  endtask

  // Runs one burst from IDLE. stall_k: descriptor whose done is held back
  // until the watchdog limit (stall_done=1 gives done in the expiry cycle).
  // abort_k: descriptor during whose first RUN cycle i_abort is pulsed.
  task automatic burst(input int n, input int stall_k, input bit stall_done, input int abort_k);
    logic [7:0] dsc;
    logic       toc_e;
    int         d;
    bus.i_start     = 1'b1;
    bus.i_cmd_count = 4'(n);
    tick();
    err_m = 1'b0;
    if (n == 0) begin
      check("zero_done", bus.o_done, 1);
      check("zero_rd", bus.o_regf_rd_en, 0);
      tick();
      hold_cp = 0; hold_toc = 0; hold_mode = 0;
      check("zero_done_clr", bus.o_done, 0);
      check("zero_mode_clr", bus.o_mode, 0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      check("fetch_rd", bus.o_regf_rd_en, 1);
      check("fetch_addr", bus.o_regf_addr, int'(BASE) + ptr_m);
      check("fetch_hold", {bus.o_cp, bus.o_toc, bus.o_mode}, {hold_cp, hold_toc, hold_mode});
      check("fetch_en", bus.o_hdrengine_en, (k > 0));
      check("fetch_err", bus.o_error, err_m);
      tick();
      check("load_rd", bus.o_regf_rd_en, 0);
      check("load_hold", {bus.o_cp, bus.o_toc, bus.o_mode}, {hold_cp, hold_toc, hold_mode});
      dsc       = desc_mem[ptr_m];
      toc_e     = dsc[1] | (n - k == 1);
      hold_cp   = dsc[0];
      hold_toc  = toc_e;
      hold_mode = dsc[4:2];
      tick();
      check("desc_out", {bus.o_cp, bus.o_toc, bus.o_mode}, {hold_cp, hold_toc, hold_mode});
      if (dsc[4:2] != 3'd6) begin
        err_m = 1'b1;
        check("badmode_err", bus.o_error, 1);
        check("badmode_en", bus.o_hdrengine_en, 0);
        tick();
        check("badmode_idle_en", bus.o_hdrengine_en, 0);
        check("badmode_no_done", bus.o_done, 0);
        check("badmode_sticky", bus.o_error, 1);
        return;
      end
      check("run_en", bus.o_hdrengine_en, 1);
      if (k == abort_k) begin
        bus.i_abort = 1'b1;
        tick();
        check("abort_en", bus.o_hdrengine_en, 0);
        check("abort_err", bus.o_error, err_m);
        tick();
        check("abort_no_done", bus.o_done, 0);
        check("abort_no_rd", bus.o_regf_rd_en, 0);
        return;
      end
      d = (k == stall_k) ? TMO - 1 : $urandom_range(0, 4);
      for (int j = 0; j < d; j++) begin
        bus.i_start     = ($urandom_range(0, 7) == 0);
        bus.i_cmd_count = 4'($urandom);
        tick();
        check("run_hold_en", bus.o_hdrengine_en, 1);
        check("run_no_err", bus.o_error, 0);
      end
      if (k == stall_k && !stall_done) begin
        tick();
        err_m = 1'b1;
        check("tmo_err", bus.o_error, 1);
        check("tmo_en", bus.o_hdrengine_en, 0);
        tick();
        check("tmo_sticky", bus.o_error, 1);
        check("tmo_no_done", bus.o_done, 0);
        return;
      end
      drive_done();
      ptr_m = (ptr_m + 1) % DEPTH;
      tick();
      if (toc_e) begin
        d = $urandom_range(0, 3);
        for (int j = 0; j < d; j++) begin
          bus.i_ccc_done = 1'($urandom);
          tick();
          check("exit_en", bus.o_hdrengine_en, 1);
          check("exit_no_done", bus.o_done, 0);
        end
        bus.i_hdrengine_done = 1'b1;
        tick();
        check("done_pulse", bus.o_done, 1);
        check("done_en_off", bus.o_hdrengine_en, 0);
        check("done_err", bus.o_error, 0);
        tick();
        hold_cp = 0; hold_toc = 0; hold_mode = 0;
        check("done_clr", bus.o_done, 0);
        check("desc_clr", {bus.o_cp, bus.o_toc, bus.o_mode}, 0);
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_cmd_count = 0; bus.i_regf_rd_data = 0;
    bus.i_ccc_done = 0; bus.i_ddr_mode_done = 0; bus.i_hdrengine_done = 0;
    for (int s = 0; s < DEPTH; s++) desc_mem[s] = mk(0, 0, 3'd6);
    tick(); tick();
    check("rst_addr", bus.o_regf_addr, BASE);
    check("rst_outs", {bus.o_regf_rd_en, bus.o_hdrengine_en, bus.o_cp, bus.o_toc,
                       bus.o_mode, bus.o_done, bus.o_error}, 0);
    rst_n = 1'b1;
    tick();

    // Three plain descriptors, last TOC forced.
    for (int s = 0; s < 3; s++) desc_mem[s] = mk(0, 0, 3'd6);
    burst(3, -1, 0, -1);
    // CP changes 1 -> 0 across descriptors.
    desc_mem[3] = mk(1, 0, 3'd6);
    desc_mem[4] = mk(0, 0, 3'd6);
    burst(2, -1, 0, -1);
    // Illegal MODE.
    desc_mem[5] = mk(1, 0, 3'd3);
    burst(1, -1, 0, -1);
    desc_mem[5] = mk(0, 0, 3'd6);
    burst(1, -1, 0, -1);
    // Ring wrap from slot 6.
    for (int s = 0; s < DEPTH; s++) desc_mem[s] = mk(s[0], 0, 3'd6);
    burst(4, -1, 0, -1);
    // Watchdog expiry, then done landing exactly in the expiry cycle.
    burst(2, 0, 0, -1);
    bus.i_abort = 1'b1;
    tick();
    check("idle_abort_err_kept", bus.o_error, 1);
    burst(2, 1, 1, -1);
    // Empty burst and abort mid-RUN.
    burst(0, -1, 0, -1);
    burst(3, -1, 0, 1);

    // Reset in the middle of a burst returns ptr to the start of the ring.
    bus.i_start = 1'b1; bus.i_cmd_count = 4'd3;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_en", bus.o_hdrengine_en, 0);
    check("midrst_addr", bus.o_regf_addr, BASE);
    tick();
    rst_n = 1'b1;
    ptr_m = 0; hold_cp = 0; hold_toc = 0; hold_mode = 0; err_m = 0;
    tick();
    burst(1, -1, 0, -1);

    for (int it = 0; it < 40; it++) begin
      int n;
      int ab;
      fill_random();
      n  = $urandom_range(0, 15);
      ab = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      burst(n, -1, 0, ab);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
